// File: rtl/cic_decimator.sv
// Multi-stage CIC decimator: integrators at input rate, decimating switch, combs at output rate.
// Optional round-half-up before truncation when CIC_ROUND_EN is defined (default: floor).
module cic_decimator #(
    parameter int WIDTH  = 16,
    parameter int RATE   = 8,
    parameter int STAGES = 3
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_in_data,
    input  logic             i_in_valid,
    output logic [WIDTH-1:0] o_out_data,
    output logic             o_out_valid
);

    localparam int LOG2_RATE = $clog2(RATE);
    localparam int SHIFT     = STAGES * LOG2_RATE;
    localparam int ACC_W     = WIDTH + SHIFT;
    localparam logic [LOG2_RATE-1:0] CNT_MAX = LOG2_RATE'(RATE - 1);

`ifdef CIC_ROUND_EN
    localparam logic [ACC_W-1:0] ROUND_ADD = ACC_W'(1) << (SHIFT - 1);
`else
    localparam logic [ACC_W-1:0] ROUND_ADD = '0;
`endif

    logic [ACC_W-1:0]     r_int      [STAGES];
    logic [ACC_W-1:0]     w_int_next [STAGES];
    logic [ACC_W-1:0]     w_in_ext;
    logic [LOG2_RATE-1:0] r_count;
    logic                 w_dec_event;

    // r_pipe[0] is the decimation register; r_pipe[k] feeds comb stage k.
    logic [ACC_W-1:0]     r_pipe     [STAGES];
    logic [ACC_W-1:0]     r_dly      [STAGES];
    logic [ACC_W-1:0]     w_diff     [STAGES];
    logic [STAGES-1:0]    r_pv;
    logic [ACC_W-1:0]     w_final;
    logic [WIDTH-1:0]     r_out;
    logic                 r_out_valid;

    assign w_dec_event = i_in_valid && (r_count == CNT_MAX);

    // Every add/subtract wraps modulo 2^ACC_W; the CIC relies on this.
    always_comb begin
        w_in_ext      = {{SHIFT{i_in_data[WIDTH-1]}}, i_in_data};
        w_int_next[0] = r_int[0] + w_in_ext;
        for (int k = 1; k < STAGES; k++) begin
            w_int_next[k] = r_int[k] + r_int[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            w_diff[k] = r_pipe[k] - r_dly[k];
        end
        w_final = w_diff[STAGES-1] + ROUND_ADD;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int k = 0; k < STAGES; k++) begin
                r_int[k]  <= '0;
                r_pipe[k] <= '0;
                r_dly[k]  <= '0;
            end
            r_count     <= '0;
            r_pv        <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (i_in_valid) begin
                for (int k = 0; k < STAGES; k++) begin
                    r_int[k] <= w_int_next[k];
                end
                r_count <= w_dec_event ? '0 : r_count + 1'b1;
            end

            r_pv[0] <= w_dec_event;
            if (w_dec_event) begin
                r_pipe[0] <= w_int_next[STAGES-1];
            end

            // Each comb stage owns its own valid bit, so back-to-back results can overlap.
            for (int k = 0; k < STAGES; k++) begin
                if (r_pv[k]) begin
                    r_dly[k] <= r_pipe[k];
                end
            end
            for (int k = 0; k < STAGES - 1; k++) begin
                r_pv[k+1] <= r_pv[k];
                if (r_pv[k]) begin
                    r_pipe[k+1] <= w_diff[k];
                end
            end

            r_out_valid <= r_pv[STAGES-1];
            if (r_pv[STAGES-1]) begin
                r_out <= w_final[ACC_W-1:SHIFT];
            end
        end
    end

    assign o_out_data  = r_out;
    assign o_out_valid = r_out_valid;

endmodule

// File: tb/tb_cic_decimator.sv
// Scoreboard bench for cic_decimator (defaults WIDTH=16, RATE=8, STAGES=3).
// Expected outputs are hand-derived; define CIC_ROUND_EN here too when the DUT uses it.
module tb_cic_decimator;

    typedef logic signed [15:0] s16;
    typedef struct {
        s16 data;
        int when;
    } exp_t;

`ifdef CIC_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic i_clock = 1'b0;
    logic i_reset;
    s16   i_in_data;
    logic i_in_valid;
    s16   o_out_data;
    logic o_out_valid;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    exp_t q[$];

    cic_decimator #(.WIDTH(16), .RATE(8), .STAGES(3)) dut (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_in_data  (i_in_data),
        .i_in_valid (i_in_valid),
        .o_out_data (o_out_data),
        .o_out_valid(o_out_valid)
    );

    always #5 i_clock = ~i_clock;
    always @(posedge i_clock) cyc <= cyc + 1;

    // Monitor: every strobe must match the head of the queue in value and cycle.
    always @(negedge i_clock) begin
        exp_t e;
        if (o_out_valid === 1'b1) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_strobe: got data=%0d at cycle %0d, required no strobe",
                         o_out_data, cyc);
            end else begin
                e = q.pop_front();
                if (o_out_data !== e.data || cyc != e.when) begin
                    fails++;
                    $display("FAIL strobe: got data=%0d at cycle %0d, required data=%0d at cycle %0d",
                             o_out_data, cyc, e.data, e.when);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end

    task automatic push_exp(input s16 d);
        exp_t e;
        e.data = d;
        e.when = cyc + 3;
        q.push_back(e);
    endtask

    task automatic send(input s16 x, input int n, input int gap, input bit push, input s16 e);
        for (int i = 0; i < n; i++) begin
            i_in_data  = x;
            i_in_valid = 1'b1;
            @(posedge i_clock); #1;
            i_in_valid = 1'b0;
            if (push && i == n - 1) push_exp(e);
            repeat (gap) begin @(posedge i_clock); #1; end
        end
    endtask

    // Group 0 uses x0, later groups x1; expected outputs e0, e1, e2, then erest.
    task automatic groups(input s16 x0, input s16 x1, input int ng, input int gap,
                          input s16 e0, input s16 e1, input s16 e2, input s16 erest);
        for (int g = 0; g < ng; g++) begin
            send((g == 0) ? x0 : x1, 8, gap, 1'b1,
                 (g == 0) ? e0 : (g == 1) ? e1 : (g == 2) ? e2 : erest);
        end
    endtask

    task automatic do_reset(input int n);
        i_reset    = 1'b1;
        i_in_valid = 1'b0;
        @(posedge i_clock); #1;
        tests++;
        if (o_out_valid !== 1'b0 || o_out_data !== 16'sd0) begin
            fails++;
            $display("FAIL reset_state: got valid=%b data=%0d, required valid=0 data=0",
                     o_out_valid, o_out_data);
        end
        repeat (n - 1) begin @(posedge i_clock); #1; end
        i_reset = 1'b0;
    endtask

    task automatic drain(input s16 hold);
        int k = 0;
        while (q.size() != 0 && k < 60) begin
            @(posedge i_clock); #1;
            k++;
        end
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL missing_strobes: got %0d outstanding, required 0", q.size());
            q.delete();
        end
        repeat (10) begin @(posedge i_clock); #1; end
        tests++;
        if (o_out_data !== hold) begin
            fails++;
            $display("FAIL hold_value: got %0d, required %0d", o_out_data, hold);
        end
    endtask

    initial begin
        i_reset    = 1'b1;
        i_in_valid = 1'b0;
        i_in_data  = '0;

        // Idle input: no strobes, output stays 0.
        do_reset(2);
        repeat (1000) begin @(posedge i_clock); #1; end
        drain(16'sd0);

        // DC +1000, continuous valid.
        do_reset(2);
        groups(16'sd1000, 16'sd1000, 8, 0, 16'sd109, RND ? 16'sd766 : 16'sd765, 16'sd1000, 16'sd1000);
        drain(16'sd1000);

        // DC full-scale negative; integrators wrap many times.
        do_reset(2);
        groups(-16'sd32768, -16'sd32768, 32, 0, -16'sd3584, -16'sd25088, -16'sd32768, -16'sd32768);
        drain(-16'sd32768);

        // DC +1000 with valid every 3rd cycle.
        do_reset(2);
        groups(16'sd1000, 16'sd1000, 8, 2, 16'sd109, RND ? 16'sd766 : 16'sd765, 16'sd1000, 16'sd1000);
        drain(16'sd1000);

        // Reset after 5 samples of group 2, then a fresh-start sequence.
        do_reset(2);
        send(16'sd1000, 8, 0, 1'b1, 16'sd109);
        send(16'sd1000, 5, 0, 1'b0, 16'sd0);
        drain(16'sd109);
        do_reset(3);
        groups(16'sd1000, 16'sd1000, 2, 0, 16'sd109, RND ? 16'sd766 : 16'sd765, 16'sd0, 16'sd0);
        drain(RND ? 16'sd766 : 16'sd765);

        // Reset right after a decimation event: in-flight result is discarded.
        do_reset(2);
        send(16'sd1000, 8, 0, 1'b0, 16'sd0);
        do_reset(2);
        drain(16'sd0);
        groups(16'sd1000, 16'sd1000, 1, 0, 16'sd109, 16'sd0, 16'sd0, 16'sd0);
        drain(16'sd109);

        // Short pulses: raw values 56/512, 336/512, 120/512 times amplitude.
        do_reset(2);
        groups(16'sd1, 16'sd0, 4, 0, 16'sd0, RND ? 16'sd1 : 16'sd0, 16'sd0, 16'sd0);
        drain(16'sd0);
        do_reset(2);
        groups(16'sd100, 16'sd0, 4, 0, RND ? 16'sd11 : 16'sd10, RND ? 16'sd66 : 16'sd65, 16'sd23, 16'sd0);
        drain(16'sd0);
        do_reset(2);
        groups(-16'sd100, 16'sd0, 4, 1, -16'sd11, -16'sd66, RND ? -16'sd23 : -16'sd24, 16'sd0);
        drain(16'sd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
